// File: rtl/fpu_issue_arbiter.sv
// Two-requester issue arbiter for a shared FPU normalize/round unit with in-order result return.
// Define FPU_ISSUE_ARB_FIXED_PRIORITY_EN to use fixed priority (port 0 wins) instead of round-robin.
module fpu_issue_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int RES_WIDTH    = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  unit_valid,
  input  logic                  unit_ready,
  output logic [DATA_WIDTH-1:0] unit_data,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [RES_WIDTH-1:0]  res_data,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [RES_WIDTH-1:0]  rsp0_data,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [RES_WIDTH-1:0]  rsp1_data,
  output logic [4:0]            inflight,
  output logic                  tag_error
);

  localparam int              PTR_W    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [4:0]       MAX_CNT  = 5'(MAX_INFLIGHT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_INFLIGHT - 1);

  logic                    unit_valid_r;
  logic [DATA_WIDTH-1:0]   unit_data_r;
  logic [MAX_INFLIGHT-1:0] tag_mem_r;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [4:0]              count_r;
  logic                    tag_error_r;

  logic can_accept_s;
  logic grant0_s;
  logic grant1_s;
  logic push_s;
  logic pop_s;
  logic nonempty_s;
  logic head_tag_s;
  logic orphan_s;
  logic res_ready_s;

  // Pointers advance modulo MAX_INFLIGHT, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_next = {PTR_W{1'b0}};
    end else begin
      ptr_next = p + PTR_W'(1);
    end
  endfunction

`ifdef FPU_ISSUE_ARB_FIXED_PRIORITY_EN
  // Fixed-priority grant: port 0 always wins a tie
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end
`else
  logic last_grant_r;

  // Round-robin grant: on a tie, favour the port that did not win last
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = last_grant_r;
      grant1_s = ~last_grant_r;
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Round-robin pointer moves only when a request is actually taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (push_s) begin
      last_grant_r <= grant1_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Accept only when the output slot frees this cycle and a tag slot is available.
  assign can_accept_s = rst_n & (~unit_valid_r | unit_ready) & (count_r < MAX_CNT);
  assign req0_ready   = grant0_s & can_accept_s;
  assign req1_ready   = grant1_s & can_accept_s;
  assign push_s       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign nonempty_s = (count_r != 5'd0);
  assign head_tag_s = tag_mem_r[rd_ptr_r];
  assign orphan_s   = res_valid & ~nonempty_s;

  // Result steering: back-pressure from the owning requester, drop orphans
  always_comb begin
    res_ready_s = 1'b1;
    if (nonempty_s) begin
      res_ready_s = head_tag_s ? rsp1_ready : rsp0_ready;
    end else begin
      res_ready_s = 1'b1;
    end
  end

  assign res_ready  = res_ready_s;
  assign pop_s      = rst_n & res_valid & res_ready_s & nonempty_s;
  assign rsp0_valid = rst_n & res_valid & nonempty_s & ~head_tag_s;
  assign rsp1_valid = rst_n & res_valid & nonempty_s & head_tag_s;
  assign rsp0_data  = res_data;
  assign rsp1_data  = res_data;

  // Issue output register: holds the operation until the unit takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      unit_valid_r <= 1'b0;
      unit_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (push_s) begin
      unit_valid_r <= 1'b1;
      unit_data_r  <= grant1_s ? req1_data : req0_data;
    end else if (unit_ready) begin
      unit_valid_r <= 1'b0;
    end else begin
      unit_valid_r <= unit_valid_r;
    end
  end

  // Tag FIFO recording which port owns each outstanding operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= 5'd0;
      tag_mem_r <= {MAX_INFLIGHT{1'b0}};
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= grant1_s;
        wr_ptr_r            <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for results that arrive with nothing outstanding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_error_r <= 1'b0;
    end else if (orphan_s) begin
      tag_error_r <= 1'b1;
    end else begin
      tag_error_r <= tag_error_r;
    end
  end

  assign unit_valid = unit_valid_r;
  assign unit_data  = unit_data_r;
  assign inflight   = count_r;
  assign tag_error  = tag_error_r;

endmodule
